// File: rtl/bp_be_cache_req_arbiter_pkg.sv
// rtl/bp_be_cache_req_arbiter_pkg.sv - shared types for the backend D$ miss-interface arbiter
package bp_be_cache_req_arbiter_pkg;

  typedef enum logic [1:0] {
    e_arb_idle = 2'd0,
    e_arb_meta = 2'd1,
    e_arb_wait = 2'd2
  } bp_be_cache_arb_state_e;

  // Grant id width for a given requester count; never narrower than one bit.
  function automatic int unsigned arb_id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int unsigned arb_grant_id_width_gp = arb_id_width(2);

endpackage

// File: rtl/bp_be_rr_pick.sv
// rtl/bp_be_rr_pick.sv - combinational round-robin selector: first set bit of v_i at or above ptr_i, wrapping
module bp_be_rr_pick
  import bp_be_cache_req_arbiter_pkg::*;
#(
  parameter int num_req_p  = 2,
  parameter int id_width_p = arb_id_width(num_req_p)
) (
  input  logic [num_req_p-1:0]  v_i,
  input  logic [id_width_p-1:0] ptr_i,
  output logic [id_width_p-1:0] id_o,
  output logic                  v_o
);

  logic [2*num_req_p-1:0] rot;
  logic [id_width_p:0]    sum;

  always_comb begin
    rot  = {v_i, v_i} >> ptr_i;
    sum  = '0;
    id_o = ptr_i;
    // Scan from the far end so the closest requester to ptr_i is written last.
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr_i} + (id_width_p + 1)'(i);
        if (sum >= (id_width_p + 1)'(num_req_p)) begin
          sum = sum - (id_width_p + 1)'(num_req_p);
        end
        id_o = sum[id_width_p-1:0];
      end
    end
  end

  assign v_o = |v_i;

endmodule

// File: rtl/bp_be_cache_req_arbiter.sv
// rtl/bp_be_cache_req_arbiter.sv - round-robin owner of the D$ miss interface, one miss outstanding
// Optional watchdog enabled by defining BP_BE_CACHE_ARB_TIMEOUT_EN.
module bp_be_cache_req_arbiter
  import bp_be_cache_req_arbiter_pkg::*;
#(
  parameter int num_req_p        = 2,
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8,
  parameter int timeout_width_p  = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p*req_width_p-1:0]      req_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  input  logic [num_req_p*metadata_width_p-1:0] req_metadata_i,
  input  logic [num_req_p-1:0]                  req_metadata_v_i,
  output logic [num_req_p-1:0]                  req_complete_o,
  output logic [req_width_p-1:0]                cache_req_o,
  output logic                                  cache_req_v_o,
  input  logic                                  cache_req_ready_i,
  output logic [metadata_width_p-1:0]           cache_req_metadata_o,
  output logic                                  cache_req_metadata_v_o,
  input  logic                                  cache_req_complete_i,
  output logic [arb_id_width(num_req_p)-1:0]    grant_id_o,
  output logic                                  busy_o,
  output logic                                  timeout_o
);

  localparam int unsigned id_width_lp = arb_id_width(num_req_p);
  typedef logic [id_width_lp-1:0] id_t;

  bp_be_cache_arb_state_e state_q, state_d;
  id_t rr_ptr_q, rr_ptr_d;
  id_t grant_id_q, grant_id_d;
  id_t winner, sel_id;
  logic any_v;

  logic [num_req_p-1:0][req_width_p-1:0]      req_arr;
  logic [num_req_p-1:0][metadata_width_p-1:0] meta_arr;

  assign req_arr  = req_i;
  assign meta_arr = req_metadata_i;

  bp_be_rr_pick #(
    .num_req_p (num_req_p),
    .id_width_p(id_width_lp)
  ) u_pick (
    .v_i  (req_v_i),
    .ptr_i(rr_ptr_q),
    .id_o (winner),
    .v_o  (any_v)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= e_arb_idle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      e_arb_idle: begin
        if (any_v && cache_req_ready_i) begin
          grant_id_d = winner;
          state_d    = e_arb_meta;
        end
      end
      e_arb_meta: begin
        if (req_metadata_v_i[grant_id_q]) state_d = e_arb_wait;
      end
      e_arb_wait: begin
        if (cache_req_complete_i) begin
          rr_ptr_d = (grant_id_q == id_t'(num_req_p - 1)) ? '0 : grant_id_q + id_t'(1);
          state_d  = e_arb_idle;
        end
      end
      default: state_d = e_arb_idle;
    endcase
  end

  // While a grant is held the request bus keeps showing the granted requester.
  assign sel_id = (state_q == e_arb_idle) ? winner : grant_id_q;

  always_comb begin
    req_ready_o            = '0;
    req_complete_o         = '0;
    cache_req_v_o          = 1'b0;
    cache_req_metadata_v_o = 1'b0;
    cache_req_o            = req_arr[sel_id];
    cache_req_metadata_o   = meta_arr[grant_id_q];
    unique case (state_q)
      e_arb_idle: begin
        cache_req_v_o       = any_v;
        req_ready_o[winner] = cache_req_ready_i;
      end
      e_arb_meta: cache_req_metadata_v_o = req_metadata_v_i[grant_id_q];
      e_arb_wait: req_complete_o[grant_id_q] = cache_req_complete_i;
      default: ;
    endcase
  end

  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q != e_arb_idle);

`ifdef BP_BE_CACHE_ARB_TIMEOUT_EN
  logic [timeout_width_p-1:0] wd_cnt_q, wd_cnt_d;
  logic                       timeout_q, timeout_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == e_arb_idle) begin
      if (any_v && cache_req_ready_i) wd_cnt_d = '0;
    end else if (wd_cnt_q != '1) begin
      wd_cnt_d = wd_cnt_q + timeout_width_p'(1);
    end
    timeout_d = timeout_q | (&wd_cnt_d);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic [timeout_width_p-1:0] unused_wd;
  assign unused_wd = '0;
  assign timeout_o = 1'b0;
`endif

  // A completion is only legal while a miss is outstanding.
  a_complete_in_wait: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    cache_req_complete_i |-> (state_q == e_arb_wait));

endmodule

// File: doc/bp_be_cache_req_arbiter.md
# bp_be_cache_req_arbiter

Round-robin arbiter that shares the single backend D$ miss interface (cache_req / cache_req_metadata / cache_req_complete) between several requesters, e.g. the D$ miss path and the page-table walker's uncached fill path. It sits between those requesters and the LCE, inside the memory stage of the backend. It holds a grant from request handshake through metadata delivery until the LCE signals completion, so at most one miss is outstanding.

## Interface
Parameters:
- num_req_p, 2: number of requesters, minimum 2.
- req_width_p, 64: width of one packed cache request.
- metadata_width_p, 8: width of one packed request metadata word.
- timeout_width_p, 16: watchdog counter width. Used only with the watchdog feature.

Ports:
- clk_i, in, 1: clock.
- reset_n_i, in, 1: reset, synchronous, active-low.
- req_i, in, num_req_p*req_width_p: requests; requester k occupies slice k.
- req_v_i, in, num_req_p: request valid per requester.
- req_ready_o, out, num_req_p: request accepted when req_v_i[k] & req_ready_o[k].
- req_metadata_i, in, num_req_p*metadata_width_p: metadata per requester.
- req_metadata_v_i, in, num_req_p: metadata valid per requester.
- req_complete_o, out, num_req_p: one-cycle completion pulse to the granted requester.
- cache_req_o, out, req_width_p: request to the LCE.
- cache_req_v_o, out, 1: request valid to the LCE.
- cache_req_ready_i, in, 1: LCE ready.
- cache_req_metadata_o, out, metadata_width_p: metadata to the LCE.
- cache_req_metadata_v_o, out, 1: metadata valid to the LCE.
- cache_req_complete_i, in, 1: LCE finished the outstanding miss.
- grant_id_o, out, $clog2(num_req_p): id of the current or last grant.
- busy_o, out, 1: arbiter is not in IDLE.
- timeout_o, out, 1: sticky watchdog flag.

## Operation
- The FSM has three states: IDLE, META, WAIT. Reset state is IDLE.
- **IDLE:**
  - The winner is the first requester with req_v_i set, scanning upward from rr_ptr and wrapping modulo num_req_p.
  - cache_req_o = req_i[winner]. cache_req_v_o = |req_v_i.
  - req_ready_o[winner] = cache_req_ready_i. All other req_ready_o bits are 0.
  - On handshake (cache_req_v_o & cache_req_ready_i): latch grant_id = winner and go to META.
- **META:**
  - cache_req_metadata_o = req_metadata_i[grant_id]. cache_req_metadata_v_o = req_metadata_v_i[grant_id].
  - When that valid is high, go to WAIT. Metadata from non-granted requesters is ignored.
- **WAIT:** on cache_req_complete_i:
  - req_complete_o[grant_id] = 1 for exactly that cycle.
  - rr_ptr = (grant_id+1) mod num_req_p.
  - Go to IDLE.
- cache_req_complete_i in IDLE or META is a protocol error. It is ignored and flagged by a simulation assertion.
- In META and WAIT: req_ready_o = 0 and cache_req_v_o = 0.
- Combinational winner choice is registered only at handshake. A requester may drop req_v_i before handshake without consequence.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_id_o 0, busy_o 0, timeout_o 0, watchdog counter 0, req_complete_o 0, cache_req_metadata_v_o 0.
- Request path IDLE→LCE is combinational (zero-cycle). The first metadata is accepted no earlier than the cycle after the handshake.
- Minimum grant tenure is 3 cycles: handshake, then metadata, then complete. The next request is offered in the cycle after the complete.
- Metadata valid and complete in the same WAIT cycle cannot occur, because metadata is consumed only in META.
- reset_n_i low in any state returns to IDLE on the next edge. Any outstanding grant is abandoned without a req_complete_o pulse.
- Wrap-around: grant_id = num_req_p-1 yields rr_ptr 0.

## Configuration
- BP_BE_CACHE_ARB_TIMEOUT_EN defined:
  - A timeout_width_p counter clears on entry to META and increments each cycle in META or WAIT, saturating at all-ones.
  - Reaching all-ones sets timeout_o, which stays set until reset.
  - The FSM itself is unaffected.
- BP_BE_CACHE_ARB_TIMEOUT_EN undefined: no counter; timeout_o tied 0.

## Structure
- A shared package holds:
  - the state enum bp_be_cache_arb_state_e (e_arb_idle, e_arb_meta, e_arb_wait);
  - the localparam for grant id width.
- One sub-module: bp_be_rr_pick, a combinational round-robin priority selector.
  - Inputs: v, ptr.
  - Outputs: winner id, any-valid.
- The FSM, grant register and watchdog stay in the top.

## Test plan
- **Single request:** req_v_i=2'b01, ready=1; metadata 1 cycle later; complete 4 cycles later.
  - Expect: handshake cycle 0, metadata_v cycle 1, req_complete_o=2'b01 cycle 5, busy_o low cycle 6.
- **Round-robin fairness:** both requesters valid continuously, LCE always ready, complete 2 cycles after metadata.
  - Expect: grant_id_o alternates 0,1,0,1, starting at 0 after reset.
- **Backpressure:** req_v_i=2'b10, cache_req_ready_i=0 for 5 cycles.
  - Expect: req_ready_o=0 throughout and state remains IDLE.
  - Then ready=1: handshake that cycle, grant_id_o=1.
- **Foreign metadata ignored:** grant to requester 0 in META; req_metadata_v_i=2'b10.
  - Expect: cache_req_metadata_v_o=0 and state remains META.
- **Reset mid-WAIT:** reset_n_i=0 for 1 cycle during WAIT.
  - Expect: next cycle IDLE, rr_ptr 0, no req_complete_o pulse.
- **Watchdog (macro on, timeout_width_p=4):** withhold complete.
  - Expect: timeout_o rises 15 cycles after entering META and stays high after the complete arrives.
